md_audio_decim: RTL and testbench



---
 rtl/md_audio_pkg.sv | 23 ++
 rtl/md_audio_decim_if.sv | 14 +
 rtl/md_audio_fifo.sv | 62 ++++++
 rtl/md_audio_decim.sv | 102 ++++++++++
 tb/tb_md_audio_decim.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_audio_pkg.sv
// Shared types for the audio decimator: signed sample, stereo pair,
// full-scale limits and a 17-to-16-bit saturating helper.
package md_audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  localparam sample_t SAMPLE_MAX = 16'sh7fff;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Top two bits disagree only when the value left the 16-bit range.
  function automatic sample_t saturate(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      return v[16] ? SAMPLE_MIN : SAMPLE_MAX;
    end
    return v[15:0];
  endfunction

endpackage

// File: rtl/md_audio_decim_if.sv
// Valid/ready stereo sample stream between decimator and audio serializer.
// master drives valid/l/r and reads ready; slave is the consumer side.
interface md_audio_decim_if;
  import md_audio_pkg::*;

  logic    valid;
  logic    ready;
  sample_t l;
  sample_t r;

  modport master (output valid, l, r, input ready);
  modport slave  (input valid, l, r, output ready);

endinterface

// File: rtl/md_audio_fifo.sv
// Synchronous show-ahead FIFO of stereo samples; dout reads 0 when empty.
// Ports: clk, rst, push, pop, din, dout, full, empty, fill.
module md_audio_fifo
  import md_audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  stereo_t                    din,
  output stereo_t                    dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] fill
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  stereo_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (fill == '0);
  assign full  = (fill == CW'(DEPTH));

  // A pop frees the slot the push lands in, so full+pop still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/md_audio_decim.sv
// Box-car stereo decimator: averages A_L/A_R over 2^SHIFT MCLKs into a FIFO.
// Ports: MCLK, ext_reset, enable, A_L, A_R, out (stream), fill, overflow, drop_count, clear_ovf.
module md_audio_decim
  import md_audio_pkg::*;
#(
  parameter int SHIFT      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            MCLK,
  input  logic                            ext_reset,
  input  logic                            enable,
  input  sample_t                         A_L,
  input  sample_t                         A_R,
  md_audio_decim_if.master                out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill,
  output logic                            overflow,
  output logic [7:0]                      drop_count,
  input  logic                            clear_ovf
);
  localparam int AW = 16 + SHIFT;
  localparam logic [SHIFT-1:0] PH_MAX = '1;
  localparam logic signed [AW:0] RND =
    {{AW{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [SHIFT-1:0]     phase;
  logic signed [AW-1:0] acc_l;
  logic signed [AW-1:0] acc_r;
  logic signed [AW:0]   sum_l;
  logic signed [AW:0]   sum_r;
  logic signed [16:0]   q_l;
  logic signed [16:0]   q_r;
  logic                 term;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 drop;
  stereo_t              din;
  stereo_t              dout;

  assign term = enable && (phase == PH_MAX);
  assign pop  = out.valid && out.ready;
  assign drop = term && full && !pop;

  // Guard bit keeps the round-half-up add clear of wrap at full scale.
  assign sum_l = (AW+1)'(acc_l) + (AW+1)'(A_L) + RND;
  assign sum_r = (AW+1)'(acc_r) + (AW+1)'(A_R) + RND;
  assign q_l   = 17'(sum_l >>> SHIFT);
  assign q_r   = 17'(sum_r >>> SHIFT);

  assign din.l = saturate(q_l);
  assign din.r = saturate(q_r);

  assign out.valid = !empty;
  assign out.l     = dout.l;
  assign out.r     = dout.r;

  md_audio_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (MCLK),
    .rst   (ext_reset),
    .push  (term),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  // Disabling discards any partial window.
  always_ff @(posedge MCLK) begin
    if (ext_reset || !enable || term) begin
      phase <= '0;
      acc_l <= '0;
      acc_r <= '0;
    end else begin
      phase <= phase + 1'b1;
      acc_l <= acc_l + AW'(A_L);
      acc_r <= acc_r + AW'(A_R);
    end
  end

  // A drop in the same cycle as clear restarts the count at one.
  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hff) begin
        drop_count <= drop_count + 1'b1;
      end
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_md_audio_decim.sv
// Scoreboard bench for md_audio_decim at SHIFT=4, 1 and 2 (depth 4).
// Expected samples are queued as windows complete and compared on output.
module tb_md_audio_decim;
  import md_audio_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    en;
  logic    clr;
  logic    rdy;
  sample_t a_l;
  sample_t a_r;

  logic [2:0] fill4, fill1, fill2;
  logic       ovf4, ovf1, ovf2;
  logic [7:0] dc4, dc1, dc2;

  int      n_cmp = 0;
  int      n_bad = 0;
  stereo_t q[$];

  always #5 clk = ~clk;

  md_audio_decim_if if4 ();
  md_audio_decim_if if1 ();
  md_audio_decim_if if2 ();

  assign if4.ready = rdy;
  assign if1.ready = rdy;
  assign if2.ready = rdy;

  md_audio_decim #(.SHIFT(4), .FIFO_DEPTH(4)) u4 (
    .MCLK(clk), .ext_reset(rst), .enable(en), .A_L(a_l), .A_R(a_r),
    .out(if4), .fill(fill4), .overflow(ovf4), .drop_count(dc4),
    .clear_ovf(clr)
  );

  md_audio_decim #(.SHIFT(1), .FIFO_DEPTH(4)) u1 (
    .MCLK(clk), .ext_reset(rst), .enable(en), .A_L(a_l), .A_R(a_r),
    .out(if1), .fill(fill1), .overflow(ovf1), .drop_count(dc1),
    .clear_ovf(clr)
  );

  md_audio_decim #(.SHIFT(2), .FIFO_DEPTH(4)) u2 (
    .MCLK(clk), .ext_reset(rst), .enable(en), .A_L(a_l), .A_R(a_r),
    .out(if2), .fill(fill2), .overflow(ovf2), .drop_count(dc2),
    .clear_ovf(clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; rdy = 1'b0;
    a_l = '0; a_r = '0;
    q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic stereo_t avg(input int sl, input int sr, input int sh);
    stereo_t e;
    int l, r;
    l = (sl + (1 << (sh - 1))) >>> sh;
    r = (sr + (1 << (sh - 1))) >>> sh;
    if (l > 32767) l = 32767;
    if (l < -32768) l = -32768;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    e.l = 16'(l);
    e.r = 16'(r);
    return e;
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({if4.valid, if1.valid, if2.valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_valid got %b want 000",
               {if4.valid, if1.valid, if2.valid});
    end
    n_cmp++;
    if ({fill4, fill2} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_fill got %0d/%0d want 0/0", fill4, fill2);
    end
    n_cmp++;
    if ({ovf4, dc4, ovf2, dc2} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_ovf got %b/%0d want 0/0", ovf4, dc4);
    end
    n_cmp++;
    if ({if4.l, if4.r} !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_out got %0d/%0d want 0/0", if4.l, if4.r);
    end
  endtask

  task automatic test_const_gain();
    int sl = 0, sr = 0, ph = 0, got = 0;
    stereo_t e;
    do_reset();
    en = 1'b1; rdy = 1'b1; a_l = 16'sd1000; a_r = -16'sd1000;
    for (int c = 1; c <= 48; c++) begin
      sl += a_l; sr += a_r;
      if (ph == 15) begin
        q.push_back(avg(sl, sr, 4));
        sl = 0; sr = 0; ph = 0;
      end else begin
        ph++;
      end
      tick();
      if (c == 15 || c == 16 || c == 17) begin
        n_cmp++;
        if (if4.valid !== (c == 16)) begin
          n_bad++;
          $display("FAIL gain_latency c=%0d got %b want %b",
                   c, if4.valid, c == 16);
        end
      end
      if (if4.valid) begin
        got++;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL gain_out got %0d/%0d want none", if4.l, if4.r);
        end else begin
          e = q.pop_front();
          if ({if4.l, if4.r} !== e) begin
            n_bad++;
            $display("FAIL gain_out got %0d/%0d want %0d/%0d",
                     if4.l, if4.r, e.l, e.r);
          end
        end
      end
    end
    n_cmp++;
    if (got !== 3) begin
      n_bad++;
      $display("FAIL gain_count got %0d want 3", got);
    end
  endtask

  task automatic test_rounding();
    int tl[8] = '{0, 1, 32767, 32767, -32768, -32768, 5, 6};
    int tr[8] = '{-1, -2, -32768, -32768, 32767, 32767, -5, -6};
    int sl = 0, sr = 0, got = 0;
    stereo_t e;
    do_reset();
    en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        a_l = 16'(tl[i]); a_r = 16'(tr[i]);
        sl += tl[i]; sr += tr[i];
        if (i % 2 == 1) begin
          q.push_back(avg(sl, sr, 1));
          sl = 0; sr = 0;
        end
      end else begin
        en = 1'b0;
      end
      tick();
      if (if1.valid) begin
        got++;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL round_out got %0d/%0d want none", if1.l, if1.r);
        end else begin
          e = q.pop_front();
          if ({if1.l, if1.r} !== e) begin
            n_bad++;
            $display("FAIL round_out got %0d/%0d want %0d/%0d",
                     if1.l, if1.r, e.l, e.r);
          end
        end
      end
    end
    n_cmp++;
    if ({got, fill1, ovf1, dc1} !== {32'd4, 3'd0, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL round_end got n=%0d fill=%0d ovf=%b dc=%0d want 4/0/0/0",
               got, fill1, ovf1, dc1);
    end
  endtask

  task automatic test_overflow();
    int mfill = 0, mdrop = 0, got = 0;
    stereo_t e;
    do_reset();
    en = 1'b1; rdy = 1'b0;
    for (int w = 1; w <= 6; w++) begin
      for (int i = 0; i < 4; i++) begin
        a_l = 16'(w); a_r = 16'(-w);
        if (i == 3) begin
          if (mfill < 4) begin
            q.push_back(avg(4 * w, -4 * w, 2));
            mfill++;
          end else begin
            mdrop++;
          end
        end
        tick();
      end
    end
    n_cmp++;
    if ({fill2, ovf2, dc2} !== {3'(mfill), 1'b1, 8'(mdrop)}) begin
      n_bad++;
      $display("FAIL ovf_state got %0d/%b/%0d want %0d/1/%0d",
               fill2, ovf2, dc2, mfill, mdrop);
    end
    n_cmp++;
    if ({if2.l, if2.r} !== q[0]) begin
      n_bad++;
      $display("FAIL ovf_head_hold got %0d/%0d want %0d/%0d",
               if2.l, if2.r, q[0].l, q[0].r);
    end
    for (int w = 0; w < 256; w++) begin
      a_l = 16'sd50; a_r = 16'sd50;
      for (int i = 0; i < 4; i++) tick();
      if (mdrop < 255) mdrop++;
    end
    n_cmp++;
    if (dc2 !== 8'(mdrop)) begin
      n_bad++;
      $display("FAIL ovf_saturate got %0d want %0d", dc2, mdrop);
    end
    for (int i = 0; i < 4; i++) begin
      clr = (i == 3);
      tick();
    end
    clr = 1'b0;
    n_cmp++;
    if ({ovf2, dc2} !== {1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL ovf_drop_wins got %b/%0d want 1/1", ovf2, dc2);
    end
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++;
    if ({ovf2, dc2} !== 9'd0) begin
      n_bad++;
      $display("FAIL ovf_clear got %b/%0d want 0/0", ovf2, dc2);
    end
    rdy = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (if2.valid) begin
        got++;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL ovf_drain got %0d/%0d want none", if2.l, if2.r);
        end else begin
          e = q.pop_front();
          if ({if2.l, if2.r} !== e) begin
            n_bad++;
            $display("FAIL ovf_drain got %0d/%0d want %0d/%0d",
                     if2.l, if2.r, e.l, e.r);
          end
        end
      end
      tick();
    end
    n_cmp++;
    if ({got, if2.valid, fill2} !== {32'd4, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL ovf_empty got n=%0d v=%b fill=%0d want 4/0/0",
               got, if2.valid, fill2);
    end
  endtask

  task automatic test_push_pop_full();
    int got = 0;
    stereo_t e;
    do_reset();
    en = 1'b1; rdy = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      for (int i = 0; i < 4; i++) begin
        a_l = 16'(v == 5 ? 7 : v); a_r = 16'(v == 5 ? -7 : -v);
        if (v == 5 && i == 3) begin
          rdy = 1'b1;
          got++;
          n_cmp++;
          e = q.pop_front();
          if ({if2.l, if2.r} !== e) begin
            n_bad++;
            $display("FAIL pp_head got %0d/%0d want %0d/%0d",
                     if2.l, if2.r, e.l, e.r);
          end
        end
        if (i == 3) q.push_back(avg(4 * int'(a_l), 4 * int'(a_r), 2));
        tick();
      end
    end
    rdy = 1'b0;
    n_cmp++;
    if ({fill2, ovf2, dc2} !== {3'd4, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL pp_full got %0d/%b/%0d want 4/0/0", fill2, ovf2, dc2);
    end
    en = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (if2.valid) begin
        got++;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL pp_drain got %0d/%0d want none", if2.l, if2.r);
        end else begin
          e = q.pop_front();
          if ({if2.l, if2.r} !== e) begin
            n_bad++;
            $display("FAIL pp_drain got %0d/%0d want %0d/%0d",
                     if2.l, if2.r, e.l, e.r);
          end
        end
      end
      tick();
    end
    n_cmp++;
    if (got !== 5) begin
      n_bad++;
      $display("FAIL pp_count got %0d want 5", got);
    end
  endtask

  task automatic test_enable_gating();
    int got = 0;
    stereo_t e;
    do_reset();
    en = 1'b1; rdy = 1'b1; a_l = 16'sd100; a_r = 16'sd100;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (if4.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL gate_idle got %b want 0", if4.valid);
    end
    en = 1'b1; a_l = 16'sd200; a_r = -16'sd200;
    for (int c = 1; c <= 20; c++) begin
      if (c == 16) q.push_back(avg(16 * 200, -16 * 200, 4));
      tick();
      if (if4.valid) begin
        got++;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL gate_out got %0d/%0d want none", if4.l, if4.r);
        end else begin
          e = q.pop_front();
          if ({if4.l, if4.r} !== e) begin
            n_bad++;
            $display("FAIL gate_out got %0d/%0d want %0d/%0d",
                     if4.l, if4.r, e.l, e.r);
          end
        end
      end
    end
    n_cmp++;
    if (got !== 1) begin
      n_bad++;
      $display("FAIL gate_count got %0d want 1", got);
    end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    stereo_t e;
    do_reset();
    en = 1'b1; rdy = 1'b0; a_l = 16'sd3; a_r = 16'sd3;
    for (int i = 0; i < 12; i++) tick();
    a_l = 16'sd1000; a_r = 16'sd1000;
    tick();
    tick();
    n_cmp++;
    if (fill2 !== 3'd3) begin
      n_bad++;
      $display("FAIL rmid_pre got %0d want 3", fill2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({if2.valid, fill2, ovf2} !== 5'd0) begin
      n_bad++;
      $display("FAIL rmid_state got %b/%0d/%b want 0/0/0",
               if2.valid, fill2, ovf2);
    end
    q.delete();
    a_l = 16'sd9; a_r = -16'sd9; rdy = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c % 4 == 0) q.push_back(avg(36, -36, 2));
      tick();
      if (if2.valid) begin
        got++;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rmid_out got %0d/%0d want none", if2.l, if2.r);
        end else begin
          e = q.pop_front();
          if ({if2.l, if2.r} !== e) begin
            n_bad++;
            $display("FAIL rmid_out got %0d/%0d want %0d/%0d",
                     if2.l, if2.r, e.l, e.r);
          end
        end
      end
    end
    n_cmp++;
    if (got !== 2) begin
      n_bad++;
      $display("FAIL rmid_count got %0d want 2", got);
    end
  endtask

  initial begin
    test_reset();
    test_const_gain();
    test_rounding();
    test_overflow();
    test_push_pop_full();
    test_enable_gating();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
